// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU among N_REQ requesters.
// Opcodes (cmd[31:28]): MOV=0 ADD=1 SUB=2 MUL=3 DIV=4 SHR=5 SHL=6 XOR=7 AND=8 OR=9; others are rejected.
module alu_sched #(
  parameter int N_REQ     = 4,
  parameter int DATA_SIZE = 32,
  parameter int TIMEOUT   = 15,
  localparam int IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*32-1:0]        req_cmd,
  input  logic [N_REQ*DATA_SIZE-1:0] req_src0,
  input  logic [N_REQ*DATA_SIZE-1:0] req_src1,
  output logic [N_REQ-1:0]           ack,
  output logic                       err,
  output logic [DATA_SIZE-1:0]       res_lo,
  output logic [DATA_SIZE-1:0]       res_hi,
  output logic                       busy,
  output logic [IDW-1:0]             grant_id,
  output logic                       alu_start,
  output logic [31:0]                alu_cmd,
  output logic [DATA_SIZE-1:0]       alu_src0,
  output logic [DATA_SIZE-1:0]       alu_src1,
  input  logic                       alu_done,
  input  logic [DATA_SIZE-1:0]       alu_dst,
  input  logic [DATA_SIZE-1:0]       alu_dst_h
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [3:0] CMD_DIV = 4'd4;
  localparam logic [3:0] CMD_OR  = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       rr_q, rr_d, grant_q, grant_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic                 err_q, err_d, busy_q, busy_d, start_q, start_d;
  logic [DATA_SIZE-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [31:0]          cmd_q, cmd_d;
  logic [DATA_SIZE-1:0] s0_q, s0_d, s1_q, s1_d;

  logic                 found;
  logic [IDW-1:0]       pick;
  int                   cand;
  logic [31:0]          selCmd;
  logic [DATA_SIZE-1:0] selS0, selS1;
  logic                 selOk;

  // Round-robin pick: first set request at or after rr_q, wrapping.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    cand   = 0;
    selCmd = '0;
    selS0  = '0;
    selS1  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req[IDW'(cand)]) begin
        found = 1'b1;
        pick  = IDW'(cand);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (pick == IDW'(j)) begin
        selCmd = req_cmd[j*32 +: 32];
        selS0  = req_src0[j*DATA_SIZE +: DATA_SIZE];
        selS1  = req_src1[j*DATA_SIZE +: DATA_SIZE];
      end
    end
    selOk = (selCmd[31:28] <= CMD_OR) && !((selCmd[31:28] == CMD_DIV) && (selS1 == '0));
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cmd_d   = cmd_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          cmd_d   = selCmd;
          s0_d    = selS0;
          s1_d    = selS1;
          if (selOk) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_RESP;
            err_d   = 1'b1;
            lo_d    = '0;
            hi_d    = '0;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      // A done arriving on the expiry cycle takes priority over the timeout.
      S_WAIT: begin
        if (alu_done) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          lo_d    = alu_dst;
          hi_d    = alu_dst_h;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          lo_d    = '0;
          hi_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        rr_d    = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE);
    ack_d   = (state_d == S_RESP) ? (N_REQ'(1) << grant_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      cmd_q   <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cmd_q   <= cmd_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign res_lo    = lo_q;
  assign res_hi    = hi_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;
  assign alu_start = start_q;
  assign alu_cmd   = cmd_q;
  assign alu_src0  = s0_q;
  assign alu_src1  = s1_q;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed scenarios plus random traffic against a transaction-level model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_sched;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*32-1:0]   req_cmd;
  logic [N*DW-1:0]   req_src0, req_src1;
  logic [N-1:0]      ack;
  logic              err, busy, alu_start, alu_done;
  logic [DW-1:0]     res_lo, res_hi, alu_src0, alu_src1, alu_dst, alu_dst_h;
  logic [1:0]        grant_id;
  logic [31:0]       alu_cmd;

  int checks = 0;
  int errors = 0;
  int modelRr = 0;
  int aluLat = 1;
  int aluTimer = 0;
  int startCount = 0;

  alu_sched #(.N_REQ(N), .DATA_SIZE(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd),
    .req_src0(req_src0), .req_src1(req_src1),
    .ack(ack), .err(err), .res_lo(res_lo), .res_hi(res_hi),
    .busy(busy), .grant_id(grant_id), .alu_start(alu_start),
    .alu_cmd(alu_cmd), .alu_src0(alu_src0), .alu_src1(alu_src1),
    .alu_done(alu_done), .alu_dst(alu_dst), .alu_dst_h(alu_dst_h)
  );

  always #5 clk = ~clk;

  // Reference ALU result as a 64-bit {hi, lo} pair.
  function automatic logic [63:0] aluFunc(input logic [31:0] cmd, input logic [31:0] a, input logic [31:0] b);
    case (cmd[31:28])
      4'd1:    aluFunc = {32'b0, a} + {32'b0, b};
      4'd2:    aluFunc = {32'b0, a} - {32'b0, b};
      4'd3:    aluFunc = {32'b0, a} * {32'b0, b};
      default: aluFunc = {~a, a ^ b ^ cmd};
    endcase
  endfunction

  // Behavioural ALU: answers aluLat cycles after seeing alu_start; aluLat=0 never answers.
  always @(negedge clk) begin
    alu_done = 1'b0;
    if (aluTimer > 0) begin
      aluTimer = aluTimer - 1;
      if (aluTimer == 0) begin
        alu_done = 1'b1;
        {alu_dst_h, alu_dst} = aluFunc(alu_cmd, alu_src0, alu_src1);
      end
    end
    if (alu_start) begin
      startCount = startCount + 1;
      if (aluLat > 0) aluTimer = aluLat;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic setReq(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_cmd[i*32 +: 32] = {op, 28'($urandom)};
    req_src0[i*DW +: DW] = a;
    req_src1[i*DW +: DW] = b;
  endtask

  // Random commands for every requester; includes invalid opcodes and divide-by-zero.
  task automatic applyStimulus(input logic [N-1:0] mask, input bit onlyValid);
    logic [3:0]  op;
    logic [31:0] b;
    for (int i = 0; i < N; i++) begin
      op = onlyValid ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 11));
      b  = $urandom;
      if (op == 4'd4 && $urandom_range(0, 3) == 0) b = '0;
      setReq(i, op, $urandom, b);
    end
    req = mask;
  endtask

  // One transaction from the IDLE sampling edge to the idle cycle after ack.
  task automatic runTxn(input string tag, input bit dropEarly);
    int win, lat, n, c, startsBefore;
    bit expErr, ok;
    logic [63:0] res;
    logic [31:0] cmd, a, b;
    win = -1;
    for (int i = 0; i < N; i++) begin
      c = (modelRr + i) % N;
      if (win < 0 && req[c]) win = c;
    end
    cmd = req_cmd[win*32 +: 32];
    a   = req_src0[win*DW +: DW];
    b   = req_src1[win*DW +: DW];
    ok  = (cmd[31:28] <= 4'd9) && !(cmd[31:28] == 4'd4 && b == 0);
    if (!ok) begin
      expErr = 1'b1; res = '0; lat = 1;
    end else if (aluLat >= 1 && aluLat <= TO) begin
      expErr = 1'b0; res = aluFunc(cmd, a, b); lat = aluLat + 2;
    end else begin
      expErr = 1'b1; res = '0; lat = TO + 2;
    end
    startsBefore = startCount;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (dropEarly && n == 1) req[win] = 1'b0;
    end while (ack == '0 && n < 40);
    checkOutput({tag, ".latency"}, 64'(n), 64'(lat));
    checkOutput({tag, ".ack"}, 64'(ack), 64'(1 << win));
    checkOutput({tag, ".err"}, 64'(err), 64'(expErr));
    checkOutput({tag, ".res_lo"}, 64'(res_lo), 64'(res[31:0]));
    checkOutput({tag, ".res_hi"}, 64'(res_hi), 64'(res[63:32]));
    checkOutput({tag, ".grant_id"}, 64'(grant_id), 64'(win));
    checkOutput({tag, ".starts"}, 64'(startCount - startsBefore), 64'(ok ? 1 : 0));
    @(negedge clk);
    checkOutput({tag, ".ack_pulse"}, 64'(ack), 64'(0));
    checkOutput({tag, ".idle_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, ".hold_lo"}, 64'(res_lo), 64'(res[31:0]));
    checkOutput({tag, ".hold_err"}, 64'(err), 64'(expErr));
    modelRr = (win + 1) % N;
  endtask

  initial begin
    bit ackSeen, busySeen;
    rst = 1'b0; req = '0; req_cmd = '0; req_src0 = '0; req_src1 = '0;
    alu_done = 1'b0; alu_dst = '0; alu_dst_h = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.ack", 64'(ack), 64'(0));
    checkOutput("reset.err", 64'(err), 64'(0));
    checkOutput("reset.busy", 64'(busy), 64'(0));
    checkOutput("reset.alu_start", 64'(alu_start), 64'(0));
    checkOutput("reset.res_lo", 64'(res_lo), 64'(0));
    checkOutput("reset.res_hi", 64'(res_hi), 64'(0));
    checkOutput("reset.grant_id", 64'(grant_id), 64'(0));
    checkOutput("reset.alu_cmd", 64'(alu_cmd), 64'(0));
    checkOutput("reset.alu_src0", 64'(alu_src0), 64'(0));

    $display("[TB] ADD with carry, requester 2");
    rst = 1'b1; modelRr = 0; aluLat = 1;
    setReq(2, 4'd1, 32'hFFFF_FFFF, 32'h1);
    req = 4'b0100;
    runTxn("add", 1'b0);

    $display("[TB] divide by zero, requester 1");
    setReq(1, 4'd4, $urandom, 32'h0);
    req = 4'b0010;
    runTxn("div0", 1'b0);

    $display("[TB] contention, all requesters held");
    applyStimulus(4'b1111, 1'b1);
    for (int t = 0; t < 5; t++) runTxn("contend", 1'b0);

    $display("[TB] timeout and race");
    setReq(0, 4'd3, $urandom, $urandom);
    req = 4'b0001; aluLat = 0;
    runTxn("timeout", 1'b0);
    req = 4'b0001; aluLat = TO;
    runTxn("race", 1'b0);
    req = 4'b0001; aluLat = TO + 1;
    runTxn("late", 1'b0);

    $display("[TB] owner drops req early");
    setReq(3, 4'd2, $urandom, $urandom);
    req = 4'b1000; aluLat = 3;
    runTxn("drop", 1'b1);

    $display("[TB] reset during WAIT");
    setReq(2, 4'd1, $urandom, $urandom);
    req = 4'b0100; aluLat = 6;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; req = '0;
    checkOutput("midrst.busy", 64'(busy), 64'(0));
    checkOutput("midrst.alu_start", 64'(alu_start), 64'(0));
    checkOutput("midrst.res_lo", 64'(res_lo), 64'(0));
    checkOutput("midrst.alu_cmd", 64'(alu_cmd), 64'(0));
    ackSeen = 1'b0; busySeen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      ackSeen  = ackSeen | (ack != '0);
      busySeen = busySeen | busy;
    end
    checkOutput("midrst.no_ack", 64'(ackSeen), 64'(0));
    checkOutput("midrst.stay_idle", 64'(busySeen), 64'(0));
    modelRr = 0; aluLat = 2;
    applyStimulus(4'b1111, 1'b1);
    runTxn("after_rst", 1'b0);

    $display("[TB] random traffic");
    for (int t = 0; t < 40; t++) begin
      aluLat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
      applyStimulus(4'($urandom_range(1, 15)), 1'b0);
      runTxn("random", 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
